// File: rtl/pmu_change_sequencer_if.sv
// rtl/pmu_change_sequencer_if.sv - request byte channel and change strobe channel of the sequencer
interface pmu_change_sequencer_if;
  logic       req_valid;
  logic [7:0] req_data;
  logic       req_ready;
  logic       change;
  logic [7:0] change_vector;

  modport master (output req_valid, req_data, input req_ready, change, change_vector);
  modport slave  (input req_valid, req_data, output req_ready, change, change_vector);
endinterface

// File: rtl/pmu_change_sequencer.sv
// rtl/pmu_change_sequencer.sv - power-manager change initiator: request FIFO, guarded issue, auto-sleep and restore
module pmu_change_sequencer #(
  parameter int          FIFO_DEPTH   = 4,
  parameter int          GUARD_CYCLES = 16,
  parameter logic [23:0] IDLE_TIMEOUT = 24'd12000000,
  parameter logic [2:0]  SLEEP_CODE   = 3'd2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pmu_change_sequencer_if.slave bus,
  input  logic                  activity,
  input  logic                  wake,
  output logic [2:0]            clk1_sel,
  output logic [2:0]            clk2_sel,
  output logic [2:0]            clk3_sel,
  output logic                  sleeping,
  output logic                  busy,
  output logic                  req_err
);
  localparam int              PW         = $clog2(FIFO_DEPTH);
  localparam int              GW         = $clog2(GUARD_CYCLES + 1);
  localparam logic [PW:0]     FULL_COUNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [GW-1:0]   RG_LOAD    = GW'(GUARD_CYCLES);
  // The IDLE pop cycle is itself a settle cycle, so a normal issue guards one cycle less.
  localparam logic [GW-1:0]   G_LOAD     = GW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_GUARD, S_SLEEP_ISSUE, S_SLEEP, S_RESTORE, S_RGUARD
  } state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PW:0]     r_count;
  logic [7:0]      r_cur, r_vec;
  logic [2:0]      r_clk1, r_clk2, r_clk3;
  logic [8:0]      r_save;
  logic [1:0]      r_idx;
  logic [GW-1:0]   r_guard;
  logic [23:0]     r_idle;

  logic            w_push, w_pop, w_empty, w_cur_ok, w_change, w_err, w_idx_inc;
  logic [7:0]      w_vec;
  logic [2:0]      w_rcode, w_rmask;

  assign w_empty  = (r_count == '0);
  assign w_push   = bus.req_valid && bus.req_ready;
  assign w_cur_ok = (r_cur[2:0] <= 3'd4) && (r_cur[7:5] != 3'b000);
  assign w_rmask  = 3'b100 >> r_idx;

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_change  = 1'b0;
    w_err     = 1'b0;
    w_vec     = r_vec;
    w_idx_inc = 1'b0;
    case (r_idx)
      2'd0:    w_rcode = r_save[8:6];
      2'd1:    w_rcode = r_save[5:3];
      default: w_rcode = r_save[2:0];
    endcase
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_ISSUE;
        end else if (IDLE_TIMEOUT != 24'd0 && r_idle == IDLE_TIMEOUT - 24'd1) begin
          w_next = S_SLEEP_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_cur_ok) begin
          w_change = 1'b1;
          w_vec    = {r_cur[7:5], 2'b00, r_cur[2:0]};
          w_next   = (GUARD_CYCLES > 1) ? S_GUARD : S_IDLE;
        end else begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_GUARD: if (r_guard <= GW'(1)) w_next = S_IDLE;
      S_SLEEP_ISSUE: begin
        w_change = 1'b1;
        w_vec    = {3'b111, 2'b00, SLEEP_CODE};
        w_next   = S_SLEEP;
      end
      S_SLEEP: if (wake || activity || !w_empty) w_next = S_RESTORE;
      S_RESTORE: begin
        if (w_rcode == SLEEP_CODE) begin
          if (r_idx == 2'd2) w_next = S_IDLE;
          else               w_idx_inc = 1'b1;
        end else begin
          w_change = 1'b1;
          w_vec    = {w_rmask, 2'b00, w_rcode};
          w_next   = S_RGUARD;
        end
      end
      S_RGUARD: begin
        if (r_guard <= GW'(1)) begin
          if (r_idx == 2'd2) begin
            w_next = S_IDLE;
          end else begin
            w_idx_inc = 1'b1;
            w_next    = S_RESTORE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.req_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_cur    <= '0;
      r_vec    <= '0;
      r_clk1   <= 3'd4;
      r_clk2   <= 3'd3;
      r_clk3   <= 3'd0;
      r_save   <= '0;
      r_idx    <= '0;
      r_guard  <= '0;
      r_idle   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_cur    <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_change) r_vec <= w_vec;

      if (r_state == S_ISSUE && w_change) begin
        if (r_cur[7]) r_clk1 <= r_cur[2:0];
        if (r_cur[6]) r_clk2 <= r_cur[2:0];
        if (r_cur[5]) r_clk3 <= r_cur[2:0];
      end else if (r_state == S_SLEEP_ISSUE) begin
        r_save <= {r_clk1, r_clk2, r_clk3};
        r_clk1 <= SLEEP_CODE;
        r_clk2 <= SLEEP_CODE;
        r_clk3 <= SLEEP_CODE;
      end else if (r_state == S_RESTORE && w_change) begin
        if (w_rmask[2]) r_clk1 <= w_rcode;
        if (w_rmask[1]) r_clk2 <= w_rcode;
        if (w_rmask[0]) r_clk3 <= w_rcode;
      end

      if (r_state == S_ISSUE)        r_guard <= G_LOAD;
      else if (r_state == S_RESTORE) r_guard <= RG_LOAD;
      else if (r_guard != '0)        r_guard <= r_guard - 1'b1;

      if (r_state == S_SLEEP) r_idx <= '0;
      else if (w_idx_inc)     r_idx <= r_idx + 1'b1;

      if (activity || wake || w_push || w_change)
        r_idle <= '0;
      else if (r_state == S_IDLE && w_empty && r_idle != '1)
        r_idle <= r_idle + 1'b1;
    end
  end

  assign bus.req_ready     = (r_count != FULL_COUNT);
  assign bus.change        = w_change;
  assign bus.change_vector = w_vec;
  assign clk1_sel          = r_clk1;
  assign clk2_sel          = r_clk2;
  assign clk3_sel          = r_clk3;
  assign sleeping          = (r_state == S_SLEEP);
  assign busy              = (r_state != S_IDLE) || !w_empty;
  assign req_err           = w_err;
endmodule

// File: tb/tb_pmu_change_sequencer.sv
// tb/tb_pmu_change_sequencer.sv - scoreboard bench for pmu_change_sequencer with a request/sleep reference model
module tb_pmu_change_sequencer;
  localparam int         GUARD   = 16;
  localparam int         TIMEOUT = 100;
  localparam logic [2:0] SCODE   = 3'd2;
  localparam int         ERR_TAG = 256;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       activity = 1'b0;
  logic       wake = 1'b0;
  logic [2:0] clk1_sel, clk2_sel, clk3_sel;
  logic       sleeping, busy, req_err;

  pmu_change_sequencer_if bus ();

  pmu_change_sequencer #(
    .FIFO_DEPTH(4), .GUARD_CYCLES(GUARD), .IDLE_TIMEOUT(24'(TIMEOUT)), .SLEEP_CODE(SCODE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .activity(activity), .wake(wake),
    .clk1_sel(clk1_sel), .clk2_sel(clk2_sel), .clk3_sel(clk3_sel),
    .sleeping(sleeping), .busy(busy), .req_err(req_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sb[$];
  int strobe_cyc[$];
  int err_cyc[$];
  int m_sel[3];
  int m_last_vec = 0;
  logic prev_change = 1'b0;
  int mon_e;
  int mon_obs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: a request either changes the masked clocks or is rejected as an error.
  function automatic void model_byte(input logic [7:0] b);
    if (b[2:0] > 3'd4 || b[7:5] == 3'b000) begin
      sb.push_back(ERR_TAG);
    end else begin
      sb.push_back(int'({b[7:5], 2'b00, b[2:0]}));
      for (int i = 0; i < 3; i++) if (b[7 - i]) m_sel[i] = int'(b[2:0]);
    end
  endfunction

  function automatic void model_sleep();
    int saved[3];
    logic [2:0] msk;
    sb.push_back(int'({3'b111, 2'b00, SCODE}));
    for (int i = 0; i < 3; i++) saved[i] = m_sel[i];
    for (int i = 0; i < 3; i++) begin
      msk = 3'b100 >> i;
      if (saved[i] != int'(SCODE)) sb.push_back(int'({msk, 2'b00, 3'(saved[i])}));
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_change = 1'b0;
    end else begin
      if (bus.change || req_err) begin
        mon_obs = bus.change ? int'(bus.change_vector) : ERR_TAG;
        if (bus.change) begin
          check("no_back_to_back_change", int'(prev_change), 0);
          strobe_cyc.push_back(cyc);
        end else begin
          err_cyc.push_back(cyc);
        end
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_response: got 0x%0h with nothing expected", mon_obs);
        end else begin
          mon_e = sb.pop_front();
          check("response", mon_obs, mon_e);
          if (mon_e != ERR_TAG) m_last_vec = mon_e;
        end
      end else begin
        check("vector_hold", int'(bus.change_vector), m_last_vec);
      end
      prev_change = bus.change;
    end
  end

  task automatic send(input logic [7:0] b, output int acc_cyc, output int waited);
    waited = 0;
    acc_cyc = -1;
    bus.req_valid = 1'b1;
    bus.req_data = b;
    while (!bus.req_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: byte 0x%02h not accepted in 500 cycles", b);
    end else begin
      acc_cyc = cyc;
      model_byte(b);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: busy=%0b pending=%0d after %0d cycles", busy, sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic wait_sleeping(input int budget);
    int n = 0;
    while (!sleeping && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("sleep_entered", int'(sleeping), 1);
  endtask

  task automatic check_sels(input string tag);
    check({tag, "_clk1_sel"}, int'(clk1_sel), m_sel[0]);
    check({tag, "_clk2_sel"}, int'(clk2_sel), m_sel[1]);
    check({tag, "_clk3_sel"}, int'(clk3_sel), m_sel[2]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_change"}, int'(bus.change), 0);
    check({tag, "_vector"}, int'(bus.change_vector), 0);
    check({tag, "_req_err"}, int'(req_err), 0);
    check({tag, "_sleeping"}, int'(sleeping), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_req_ready"}, int'(bus.req_ready), 1);
    check_sels(tag);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, wt, t0;
    int waits[6];
    logic [7:0] b;
    bus.req_valid = 1'b0;
    bus.req_data = 8'h00;
    m_sel = '{4, 3, 0};
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    activity = 1'b1;
    @(negedge clk);

    strobe_cyc.delete();
    send(8'h81, acc, wt);
    wait_idle(100);
    check("t1_strobe_count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() == 1) check("t1_latency", strobe_cyc[0], acc + 2);
    check_sels("t1");

    strobe_cyc.delete();
    send(8'h40, acc, wt);
    send(8'h23, acc, wt);
    send(8'hE4, acc, wt);
    wait_idle(200);
    check("t2_strobe_count", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check("t2_spacing_a", strobe_cyc[1] - strobe_cyc[0], GUARD + 1);
      check("t2_spacing_b", strobe_cyc[2] - strobe_cyc[1], GUARD + 1);
    end
    check_sels("t2");

    strobe_cyc.delete();
    err_cyc.delete();
    send(8'h87, acc, wt);
    send(8'h01, acc, wt);
    wait_idle(50);
    check("t3_err_count", err_cyc.size(), 2);
    check("t3_strobe_count", strobe_cyc.size(), 0);
    if (err_cyc.size() == 2) check("t3_no_guard", err_cyc[1] - err_cyc[0], 2);
    check_sels("t3");

    send(8'h81, acc, wt);
    send(8'h41, acc, waits[0]);
    send(8'h22, acc, waits[1]);
    send(8'h63, acc, waits[2]);
    send(8'hA0, acc, waits[3]);
    send(8'hE1, acc, waits[4]);
    check("t4_four_accepts_no_stall", waits[0] + waits[1] + waits[2] + waits[3], 0);
    check("t4_fifth_stalled", int'(waits[4] > 0), 1);
    wait_idle(400);
    check_sels("t4");

    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 25)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
      end else begin
        b[7:5] = 3'($urandom_range(1, 7));
        b[4:3] = 2'($urandom);
        b[2:0] = 3'($urandom_range(0, 4));
      end
      send(b, acc, wt);
    end
    wait_idle(800);
    check_sels("rand");

    strobe_cyc.delete();
    check("s1_awake_before", int'(sleeping), 0);
    activity = 1'b0;
    t0 = cyc;
    model_sleep();
    wait_sleeping(300);
    check("s1_strobe_seen", int'(strobe_cyc.size() >= 1), 1);
    if (strobe_cyc.size() >= 1) check("s1_timeout_cycle", strobe_cyc[0], t0 + TIMEOUT);
    repeat (5) @(negedge clk);
    check("s1_still_sleeping", int'(sleeping), 1);
    check("s1_clk1_sleep", int'(clk1_sel), int'(SCODE));
    check("s1_clk2_sleep", int'(clk2_sel), int'(SCODE));
    check("s1_clk3_sleep", int'(clk3_sel), int'(SCODE));
    wake = 1'b1;
    @(negedge clk);
    wake = 1'b0;
    wait_idle(300);
    activity = 1'b1;
    check("s1_awake_after", int'(sleeping), 0);
    check_sels("s1");

    send(8'h42, acc, wt);
    wait_idle(100);
    activity = 1'b0;
    model_sleep();
    wait_sleeping(300);
    send(8'hA3, acc, wt);
    wait_idle(300);
    activity = 1'b1;
    check("s2_awake_after", int'(sleeping), 0);
    check_sels("s2");

    send(8'h81, acc, wt);
    send(8'h40, acc, wt);
    send(8'h23, acc, wt);
    wt = 0;
    while (sb.size() > 2 && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    check("r_first_issued", int'(sb.size() <= 2), 1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    sb.delete();
    m_sel = '{4, 3, 0};
    m_last_vec = 0;
    check_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    strobe_cyc.delete();
    repeat (60) @(negedge clk);
    check("r_no_strobe_after", strobe_cyc.size(), 0);
    check("r_ready_after", int'(bus.req_ready), 1);
    check("r_busy_after", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
